// File: rtl/sevenseg_scan.sv
// Time-multiplexed 4-digit seven-segment driver with per-slot blanking,
// frame-coherent input latching and optional leading-zero suppression.
module sevenseg_scan #(
  parameter int unsigned SLOT_CYCLES  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic        blank_zero,
  output logic [7:0]  seg,
  output logic [3:0]  anode,
  output logic        frame_start
);

  localparam int unsigned CNT_W = $clog2(SLOT_CYCLES);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

  typedef enum logic [1:0] {PH_OFF, PH_BLANK, PH_DRIVE} phase_t;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic        blank_zero;
  } frame_t;

  logic [CNT_W-1:0] slot_cnt, slot_cnt_nxt;
  logic [1:0]       dig, dig_nxt;
  frame_t           shadow, shadow_nxt;
  logic [7:0]       seg_nxt;
  logic [3:0]       anode_nxt;
  logic             frame_start_nxt;

  phase_t           phase;
  frame_t           cur;
  logic [3:0]       nib;
  logic             suppress;

  // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Slot/digit sequencing, frame capture and output decode.
  always_comb begin
    slot_cnt_nxt    = '0;
    dig_nxt         = '0;
    shadow_nxt      = shadow;
    frame_start_nxt = 1'b0;
    seg_nxt         = 8'hFF;
    anode_nxt       = 4'hF;
    phase           = PH_OFF;
    cur             = shadow;
    nib             = 4'h0;
    suppress        = 1'b0;

    if (enable) begin
      frame_start_nxt = (dig == 2'd0) && (slot_cnt == '0);
      if (frame_start_nxt) begin
        shadow_nxt.value      = value;
        shadow_nxt.dp         = dp;
        shadow_nxt.blank_zero = blank_zero;
      end
      // Decode from the captured frame so the first output cycle already uses it.
      cur   = shadow_nxt;
      phase = (slot_cnt < BLANK_END) ? PH_BLANK : PH_DRIVE;
      if (slot_cnt == SLOT_LAST) begin
        slot_cnt_nxt = '0;
        dig_nxt      = dig + 2'd1;
      end else begin
        slot_cnt_nxt = slot_cnt + CNT_W'(1);
        dig_nxt      = dig;
      end
    end

    nib = cur.value[{dig, 2'b00} +: 4];
    case (dig)
      2'd1:    suppress = cur.blank_zero && (cur.value[15:4]  == 12'h000);
      2'd2:    suppress = cur.blank_zero && (cur.value[15:8]  == 8'h00);
      2'd3:    suppress = cur.blank_zero && (cur.value[15:12] == 4'h0);
      default: suppress = 1'b0;
    endcase

    if (phase == PH_DRIVE) begin
      if (!suppress) begin
        anode_nxt = ~(4'b0001 << dig);
        seg_nxt   = {~cur.dp[dig], hex7(nib)};
      end else if (cur.dp[dig]) begin
        anode_nxt = ~(4'b0001 << dig);
        seg_nxt   = 8'h7F;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slot_cnt    <= '0;
      dig         <= 2'd0;
      shadow      <= '0;
      seg         <= 8'hFF;
      anode       <= 4'hF;
      frame_start <= 1'b0;
    end else begin
      slot_cnt    <= slot_cnt_nxt;
      dig         <= dig_nxt;
      shadow      <= shadow_nxt;
      seg         <= seg_nxt;
      anode       <= anode_nxt;
      frame_start <= frame_start_nxt;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Directed bench for sevenseg_scan with SLOT_CYCLES=8, BLANK_CYCLES=2.
module tb_sevenseg_scan;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b1;
  logic [15:0] value = 16'hFFFF;
  logic [3:0]  dp = 4'h0;
  logic        blank_zero = 1'b0;
  logic [7:0]  seg;
  logic [3:0]  anode;
  logic        frame_start;

  int checks = 0;
  int errors = 0;

  sevenseg_scan #(.SLOT_CYCLES(8), .BLANK_CYCLES(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .value       (value),
    .dp          (dp),
    .blank_zero  (blank_zero),
    .seg         (seg),
    .anode       (anode),
    .frame_start (frame_start)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] an, input logic [7:0] sg,
                            input logic fs);
    chk({tag, ".anode"}, {4'h0, anode}, {4'h0, an});
    chk({tag, ".seg"}, seg, sg);
    chk({tag, ".frame_start"}, {7'h0, frame_start}, {7'h0, fs});
  endtask

  // One 8-cycle slot: 2 dark cycles then 6 lit; optionally change value mid-slot.
  task automatic slot(input string tag, input logic [3:0] an, input logic [7:0] sg,
                      input logic fs0, input int chg_at, input logic [15:0] chg_val);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (i < 2) expect_out(tag, 4'hF, 8'hFF, (i == 0) ? fs0 : 1'b0);
      else       expect_out(tag, an, sg, 1'b0);
      if (i == chg_at) value = chg_val;
    end
  endtask

  initial begin
    // Held in reset with live inputs
    repeat (3) begin
      @(negedge clock);
      expect_out("reset_hold", 4'hF, 8'hFF, 1'b0);
    end

    reset = 1'b1;
    value = 16'h12AF;
    slot("scan_d0", 4'hE, 8'h8E, 1'b1, -1, 16'h0);
    slot("scan_d1", 4'hD, 8'h88, 1'b0, -1, 16'h0);
    slot("scan_d2", 4'hB, 8'hA4, 1'b0, -1, 16'h0);
    slot("scan_d3", 4'h7, 8'hF9, 1'b0, -1, 16'h0);

    // Value changes during digit1 drive; frame must stay coherent
    slot("tear_d0", 4'hE, 8'h8E, 1'b1, -1, 16'h0);
    slot("tear_d1", 4'hD, 8'h88, 1'b0, 3, 16'h0000);
    slot("tear_d2", 4'hB, 8'hA4, 1'b0, -1, 16'h0);
    slot("tear_d3", 4'h7, 8'hF9, 1'b0, -1, 16'h0);
    slot("zero_d0", 4'hE, 8'hC0, 1'b1, -1, 16'h0);
    slot("zero_d1", 4'hD, 8'hC0, 1'b0, -1, 16'h0);
    slot("zero_d2", 4'hB, 8'hC0, 1'b0, -1, 16'h0);
    slot("zero_d3", 4'h7, 8'hC0, 1'b0, -1, 16'h0);

    blank_zero = 1'b1;
    value = 16'h0050;
    slot("lz50_d0", 4'hE, 8'hC0, 1'b1, -1, 16'h0);
    slot("lz50_d1", 4'hD, 8'h92, 1'b0, -1, 16'h0);
    slot("lz50_d2", 4'hF, 8'hFF, 1'b0, -1, 16'h0);
    slot("lz50_d3", 4'hF, 8'hFF, 1'b0, -1, 16'h0);

    value = 16'h0000;
    slot("lz0_d0", 4'hE, 8'hC0, 1'b1, -1, 16'h0);
    slot("lz0_d1", 4'hF, 8'hFF, 1'b0, -1, 16'h0);
    slot("lz0_d2", 4'hF, 8'hFF, 1'b0, -1, 16'h0);
    slot("lz0_d3", 4'hF, 8'hFF, 1'b0, -1, 16'h0);

    dp = 4'b1000;
    slot("lzdp_d0", 4'hE, 8'hC0, 1'b1, -1, 16'h0);
    slot("lzdp_d1", 4'hF, 8'hFF, 1'b0, -1, 16'h0);
    slot("lzdp_d2", 4'hF, 8'hFF, 1'b0, -1, 16'h0);
    slot("lzdp_d3", 4'h7, 8'h7F, 1'b0, -1, 16'h0);

    blank_zero = 1'b0;
    value = 16'h0200;
    dp = 4'b0100;
    slot("dp_d0", 4'hE, 8'hC0, 1'b1, -1, 16'h0);
    slot("dp_d1", 4'hD, 8'hC0, 1'b0, -1, 16'h0);
    slot("dp_d2", 4'hB, 8'h24, 1'b0, -1, 16'h0);
    slot("dp_d3", 4'h7, 8'hC0, 1'b0, -1, 16'h0);

    // Enable dropped during digit2 drive
    slot("en_d0", 4'hE, 8'hC0, 1'b1, -1, 16'h0);
    slot("en_d1", 4'hD, 8'hC0, 1'b0, -1, 16'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (i < 2) expect_out("en_d2", 4'hF, 8'hFF, 1'b0);
      else       expect_out("en_d2", 4'hB, 8'h24, 1'b0);
    end
    enable = 1'b0;
    repeat (3) begin
      @(negedge clock);
      expect_out("en_off", 4'hF, 8'hFF, 1'b0);
    end
    enable = 1'b1;
    slot("en_re_d0", 4'hE, 8'hC0, 1'b1, -1, 16'h0);
    slot("en_re_d1", 4'hD, 8'hC0, 1'b0, -1, 16'h0);

    // Asynchronous reset during digit2 drive
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (i < 2) expect_out("ar_d2", 4'hF, 8'hFF, 1'b0);
      else       expect_out("ar_d2", 4'hB, 8'h24, 1'b0);
    end
    #1 reset = 1'b0;
    #1 expect_out("async_reset", 4'hF, 8'hFF, 1'b0);
    repeat (2) begin
      @(negedge clock);
      expect_out("reset_hold2", 4'hF, 8'hFF, 1'b0);
    end
    reset = 1'b1;
    slot("post_rst_d0", 4'hE, 8'hC0, 1'b1, -1, 16'h0);
    slot("post_rst_d1", 4'hD, 8'hC0, 1'b0, -1, 16'h0);
    slot("post_rst_d2", 4'hB, 8'h24, 1'b0, -1, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
